// File: rtl/ase_umsg_engine.sv
// Purpose : UMsg engine; per-slot hint/data delay timers feeding one round-robin arbiter and a single output register.
// Latency : accept at edge k -> beat at edge k+delay+2 when the output register is free; hint adds a second beat.
// Backpr. : rx_ready low holds the output beat stable and blocks grants; busy slots drop cmd_ready.
module ase_umsg_engine #(
  parameter int NUM_UMSG = 8,
  parameter int TIMER_W  = 8,
  parameter int DATA_W   = 512,
  parameter int ID_W     = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  input  logic [ID_W-1:0]     cmd_id,
  input  logic [DATA_W-1:0]   cmd_data,
  output logic                cmd_ready,
  input  logic [NUM_UMSG-1:0] hint_en,
  input  logic [TIMER_W-1:0]  hint_delay,
  input  logic [TIMER_W-1:0]  data_delay,
  output logic                rx_valid,
  output logic [27:0]         rx_hdr,
  output logic [DATA_W-1:0]   rx_data,
  input  logic                rx_ready,
  output logic                bad_id_err,
  output logic [31:0]         umsg_sent_cnt
);

  localparam int PW = (NUM_UMSG > 1) ? $clog2(NUM_UMSG) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HINT_WAIT, S_SEND_HINT, S_DATA_WAIT, S_SEND_DATA
  } slot_state_t;

  slot_state_t          state_q   [NUM_UMSG];
  slot_state_t          state_d   [NUM_UMSG];
  logic [TIMER_W-1:0]   timer_q   [NUM_UMSG];
  logic [TIMER_W-1:0]   timer_d   [NUM_UMSG];
  logic [DATA_W-1:0]    payload_q [NUM_UMSG];

  logic                 id_ok;
  logic                 slot_idle;
  logic                 cmd_acc;
  logic [NUM_UMSG-1:0]  acc_slot;
  logic [NUM_UMSG-1:0]  req;
  logic                 out_free;
  logic                 gnt_vld;
  logic [PW-1:0]        gnt_idx;
  logic [PW:0]          rr_sum;
  logic [PW-1:0]        rr_cand;
  logic [PW-1:0]        rr_ptr;

  // Command acceptance: out-of-range ids are always taken (and dropped), valid ids only when the slot is idle.
  always_comb begin
    id_ok     = (32'(cmd_id) < NUM_UMSG);
    slot_idle = 1'b0;
    acc_slot  = '0;
    for (int i = 0; i < NUM_UMSG; i++) begin
      if (32'(cmd_id) == i && state_q[i] == S_IDLE) slot_idle = 1'b1;
    end
    cmd_ready = !id_ok || slot_idle;
    cmd_acc   = cmd_valid && cmd_ready;
    for (int i = 0; i < NUM_UMSG; i++) begin
      acc_slot[i] = cmd_acc && id_ok && (32'(cmd_id) == i);
    end
  end

  // Round-robin pick of the first requesting slot at or after rr_ptr, only when the output can take a beat.
  always_comb begin
    out_free = !rx_valid || rx_ready;
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    rr_sum   = '0;
    rr_cand  = '0;
    for (int i = 0; i < NUM_UMSG; i++) begin
      req[i] = (state_q[i] == S_SEND_HINT) || (state_q[i] == S_SEND_DATA);
    end
    for (int j = 0; j < NUM_UMSG; j++) begin
      rr_sum = {1'b0, rr_ptr} + (PW+1)'(j);
      if (rr_sum >= (PW+1)'(NUM_UMSG)) rr_sum = rr_sum - (PW+1)'(NUM_UMSG);
      rr_cand = rr_sum[PW-1:0];
      if (out_free && !gnt_vld && req[rr_cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = rr_cand;
      end
    end
  end

  // Per-slot next state and timer; delays are captured only when a wait state is entered.
  always_comb begin
    for (int i = 0; i < NUM_UMSG; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      case (state_q[i])
        S_IDLE: begin
          if (acc_slot[i]) begin
            if (hint_en[i]) begin
              state_d[i] = S_HINT_WAIT;
              timer_d[i] = hint_delay;
            end else begin
              state_d[i] = S_DATA_WAIT;
              timer_d[i] = data_delay;
            end
          end
        end
        S_HINT_WAIT: begin
          if (timer_q[i] == '0) state_d[i] = S_SEND_HINT;
          else                  timer_d[i] = timer_q[i] - TIMER_W'(1);
        end
        S_SEND_HINT: begin
          if (gnt_vld && gnt_idx == PW'(i)) begin
            state_d[i] = S_DATA_WAIT;
            timer_d[i] = data_delay;
          end
        end
        S_DATA_WAIT: begin
          if (timer_q[i] == '0) state_d[i] = S_SEND_DATA;
          else                  timer_d[i] = timer_q[i] - TIMER_W'(1);
        end
        S_SEND_DATA: begin
          if (gnt_vld && gnt_idx == PW'(i)) state_d[i] = S_IDLE;
        end
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  // Slot state, timer and payload registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_UMSG; i++) begin
        state_q[i]   <= S_IDLE;
        timer_q[i]   <= '0;
        payload_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_UMSG; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
        if (acc_slot[i]) payload_q[i] <= cmd_data;
      end
    end
  end

  // Output register, arbiter pointer, sticky bad-id flag and delivered-data counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid      <= 1'b0;
      rx_hdr        <= '0;
      rx_data       <= '0;
      rr_ptr        <= '0;
      bad_id_err    <= 1'b0;
      umsg_sent_cnt <= '0;
    end else begin
      if (rx_valid && rx_ready && !rx_hdr[15]) umsg_sent_cnt <= umsg_sent_cnt + 32'd1;
      if (cmd_acc && !id_ok) bad_id_err <= 1'b1;
      if (gnt_vld) begin
        rx_valid <= 1'b1;
        rx_hdr   <= {8'h00, 4'h6, (state_q[gnt_idx] == S_SEND_HINT), 9'h000, 6'(gnt_idx)};
        rx_data  <= (state_q[gnt_idx] == S_SEND_HINT) ? '0 : payload_q[gnt_idx];
        rr_ptr   <= (gnt_idx == PW'(NUM_UMSG - 1)) ? '0 : gnt_idx + PW'(1);
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ase_umsg_engine.sv
// Bench for ase_umsg_engine: directed latency/order/reset scenarios plus random traffic,
// every cycle compared against a due-time reference model of slots, arbiter and output register.
module tb_ase_umsg_engine;

  localparam int N  = 8;
  localparam int TW = 8;
  localparam int DW = 512;
  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic [IW-1:0] cmd_id;
  logic [DW-1:0] cmd_data;
  logic          cmd_ready;
  logic [N-1:0]  hint_en;
  logic [TW-1:0] hint_delay;
  logic [TW-1:0] data_delay;
  logic          rx_valid;
  logic [27:0]   rx_hdr;
  logic [DW-1:0] rx_data;
  logic          rx_ready;
  logic          bad_id_err;
  logic [31:0]   umsg_sent_cnt;

  ase_umsg_engine #(.NUM_UMSG(N), .TIMER_W(TW), .DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_id(cmd_id), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .hint_en(hint_en), .hint_delay(hint_delay), .data_delay(data_delay),
    .rx_valid(rx_valid), .rx_hdr(rx_hdr), .rx_data(rx_data), .rx_ready(rx_ready),
    .bad_id_err(bad_id_err), .umsg_sent_cnt(umsg_sent_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 hint pending, 2 data pending; a slot
  // requests the arbiter once the edge counter has passed its due edge.
  int            m_phase [N];
  int            m_due   [N];
  logic [DW-1:0] m_pay   [N];
  int            m_ptr;
  bit            m_valid;
  logic [27:0]   m_hdr;
  logic [DW-1:0] m_data;
  bit            m_bad;
  logic [31:0]   m_cnt;
  int            e_now;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_phase[i] = 0;
      m_due[i]   = 0;
      m_pay[i]   = '0;
    end
    m_ptr = 0; m_valid = 0; m_hdr = '0; m_data = '0; m_bad = 0; m_cnt = '0; e_now = 0;
  endtask

  function automatic bit model_ready(input logic [IW-1:0] id);
    if (int'(id) >= N) return 1'b1;
    return m_phase[int'(id)] == 0;
  endfunction

  task automatic model_edge();
    int g;
    bit acc;
    int id;
    e_now++;
    g = -1;
    if (!m_valid || rx_ready) begin
      for (int i = 0; i < N; i++) begin
        int s;
        s = (m_ptr + i) % N;
        if (g < 0 && m_phase[s] != 0 && m_due[s] <= e_now - 1) g = s;
      end
    end
    acc = cmd_valid && model_ready(cmd_id);
    if (m_valid && rx_ready) begin
      if (!m_hdr[15]) m_cnt = m_cnt + 1;
      m_valid = 0;
    end
    if (g >= 0) begin
      m_valid = 1;
      m_hdr   = 28'h0060000 | 28'(g);
      if (m_phase[g] == 1) begin
        m_hdr[15]  = 1'b1;
        m_data     = '0;
        m_phase[g] = 2;
        m_due[g]   = e_now + int'(data_delay) + 1;
      end else begin
        m_data     = m_pay[g];
        m_phase[g] = 0;
      end
      m_ptr = (g + 1) % N;
    end
    if (acc) begin
      id = int'(cmd_id);
      if (id >= N) m_bad = 1;
      else begin
        m_pay[id] = cmd_data;
        if (hint_en[id]) begin m_phase[id] = 1; m_due[id] = e_now + int'(hint_delay) + 1; end
        else             begin m_phase[id] = 2; m_due[id] = e_now + int'(data_delay) + 1; end
      end
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Called just after a falling edge with inputs already driven: checks
  // cmd_ready, runs one rising edge through the model, checks outputs.
  task automatic step();
    #1;
    chk("cmd_ready", cmd_ready, model_ready(cmd_id));
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
    chk("rx_valid", rx_valid, m_valid);
    chk("rx_hdr", rx_hdr, m_hdr);
    chk("rx_data", rx_data, m_data);
    chk("bad_id_err", bad_id_err, m_bad);
    chk("sent_cnt", umsg_sent_cnt, m_cnt);
  endtask

  task automatic do_reset();
    cmd_valid = 0; cmd_id = '0; cmd_data = '0; hint_en = '0;
    hint_delay = '0; data_delay = '0; rx_ready = 1;
    rst = 1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_hdr", rx_hdr, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_cnt", umsg_sent_cnt, 0);
    chk("rst_bad_id", bad_id_err, 0);
    rst = 0;
  endtask

  initial begin
    int first, th, td, seen;
    int ids[$];
    int exp_ord[3];
    logic [27:0]   hold_hdr;
    logic [DW-1:0] hold_dat;

    rst = 1;
    do_reset();

    // Slot 3, no hint, data_delay 4: beat six edges after accept.
    cmd_valid = 1; cmd_id = 3; cmd_data = rand_data(); data_delay = 4;
    step();
    cmd_valid = 0;
    first = -1;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (rx_valid && first < 0) first = n;
    end
    chk("lat_data_only", first, 6);
    chk("cnt_one", umsg_sent_cnt, 1);

    // Slot 0 with hint: hint beat at +4, data beat at +11.
    do_reset();
    cmd_valid = 1; cmd_id = 0; cmd_data = rand_data(); hint_en = 8'h01;
    hint_delay = 2; data_delay = 5;
    step();
    cmd_valid = 0; hint_en = '0;
    th = -1; td = -1;
    for (int n = 1; n <= 25; n++) begin
      step();
      if (rx_valid && rx_hdr[15] && th < 0) th = n;
      if (rx_valid && !rx_hdr[15] && td < 0) td = n;
    end
    chk("lat_hint", th, 4);
    chk("lat_data_after_hint", td, 11);

    // Slots 1, 2, 5 become eligible together: round-robin order from pointer 0.
    do_reset();
    cmd_valid = 1;
    cmd_id = 1; cmd_data = rand_data(); data_delay = 6; step();
    cmd_id = 2; cmd_data = rand_data(); data_delay = 5; step();
    cmd_id = 5; cmd_data = rand_data(); data_delay = 4; step();
    cmd_valid = 0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (rx_valid) ids.push_back(int'(rx_hdr[5:0]));
    end
    exp_ord[0] = 1; exp_ord[1] = 2; exp_ord[2] = 5;
    chk("order_count", ids.size(), 3);
    for (int i = 0; i < 3; i++) chk("order_slot", (ids.size() > i) ? ids[i] : -1, exp_ord[i]);

    // Out-of-range id: accepted, dropped, sticky error.
    cmd_valid = 1; cmd_id = 9; cmd_data = rand_data();
    step();
    cmd_valid = 0;
    step();
    chk("bad_id_sticky", bad_id_err, 1);

    // Backpressure: beat held for 12 cycles while a second slot waits and slot 6 is re-requested.
    rx_ready = 0; data_delay = 0;
    cmd_valid = 1; cmd_id = 6; cmd_data = rand_data(); step();
    cmd_id = 7; cmd_data = rand_data(); step();
    cmd_valid = 0; step(); step();
    hold_hdr = rx_hdr; hold_dat = rx_data;
    cmd_valid = 1; cmd_id = 6;
    for (int n = 0; n < 12; n++) step();
    chk("stall_valid", rx_valid, 1);
    chk("stall_hdr", rx_hdr, hold_hdr);
    chk("stall_data", rx_data, hold_dat);
    chk("stall_busy_ready", cmd_ready, 0);
    cmd_valid = 0; rx_ready = 1;
    repeat (6) step();

    // Random traffic with periodic stall windows and changing delays.
    for (int c = 0; c < 2500; c++) begin
      cmd_valid  = ($urandom_range(0, 2) == 0);
      cmd_id     = ($urandom_range(0, 29) == 0) ? IW'($urandom_range(8, 63)) : IW'($urandom_range(0, N-1));
      cmd_data   = rand_data();
      hint_en    = N'($urandom);
      hint_delay = TW'($urandom_range(0, 7));
      data_delay = TW'($urandom_range(0, 7));
      rx_ready   = ((c / 40) % 5 == 4) ? 1'b0 : ($urandom_range(0, 3) != 0);
      step();
    end

    // Reset mid-operation with a held beat and slot 4 counting down.
    do_reset();
    rx_ready = 0; data_delay = 0;
    cmd_valid = 1; cmd_id = 2; cmd_data = rand_data(); step();
    data_delay = 20; cmd_id = 4; cmd_data = rand_data(); step();
    cmd_valid = 0;
    repeat (5) step();
    chk("pre_rst_held", rx_valid, 1);
    #2 rst = 1;
    #1;
    model_reset();
    chk("async_rst_valid", rx_valid, 0);
    chk("async_rst_hdr", rx_hdr, 0);
    chk("async_rst_cnt", umsg_sent_cnt, 0);
    @(negedge clk);
    rst = 0; rx_ready = 1;
    seen = 0;
    for (int n = 0; n < 30; n++) begin
      step();
      if (rx_valid) seen = 1;
    end
    chk("no_beat_after_rst", seen, 0);
    chk("cnt_after_rst", umsg_sent_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
